// File: rtl/simeck_enc_ctrl_if.sv
// rtl/simeck_enc_ctrl_if.sv - command/datapath signal bundle for simeck_enc_ctrl
// Optional abort/aborted pins exist only when SIMECK_CTRL_ABORT_EN is defined.
interface simeck_enc_ctrl_if #(
   parameter int DATAW = 16,
   parameter int CW    = 6
);
   logic               start;
   logic [2*DATAW-1:0] plaintext;
   logic [4*DATAW-1:0] key_in;
   logic               ready;
   logic               busy;
   logic               done;
   logic [CW-1:0]      round_cnt;
   logic [DATAW-1:0]   enc_data;
   logic [DATAW-1:0]   enc_key;
   logic               enc_reset;
   logic               enc_dctr;
   logic               enc_kctr;
   logic               enc_lfsrset;
   logic               enc_shiftregReset;
   logic               enc_save;
`ifdef SIMECK_CTRL_ABORT_EN
   logic               abort;
   logic               aborted;

   modport master (
      output start, plaintext, key_in, abort,
      input  ready, busy, done, round_cnt, enc_data, enc_key, enc_reset,
             enc_dctr, enc_kctr, enc_lfsrset, enc_shiftregReset, enc_save, aborted
   );

   modport slave (
      input  start, plaintext, key_in, abort,
      output ready, busy, done, round_cnt, enc_data, enc_key, enc_reset,
             enc_dctr, enc_kctr, enc_lfsrset, enc_shiftregReset, enc_save, aborted
   );
`else
   modport master (
      output start, plaintext, key_in,
      input  ready, busy, done, round_cnt, enc_data, enc_key, enc_reset,
             enc_dctr, enc_kctr, enc_lfsrset, enc_shiftregReset, enc_save
   );

   modport slave (
      input  start, plaintext, key_in,
      output ready, busy, done, round_cnt, enc_data, enc_key, enc_reset,
             enc_dctr, enc_kctr, enc_lfsrset, enc_shiftregReset, enc_save
   );
`endif
endinterface

// File: rtl/simeck_enc_ctrl.sv
// rtl/simeck_enc_ctrl.sv - Simeck encryptor sequencer: load, seed, round, save, done
// Optional abort/FLUSH path is compiled in with SIMECK_CTRL_ABORT_EN.
module simeck_enc_ctrl #(
   parameter int DATAW  = 16,
   parameter int ROUNDS = 32,
   parameter int CW     = 6
) (
   input  logic             clk,
   input  logic             reset,
   simeck_enc_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_LOAD_D, S_LOAD_K, S_SEED, S_ROUND, S_SAVE, S_DONE, S_FLUSH
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      phase_q, phase_d;
   logic [CW-1:0]      round_q, round_d;
   logic [2*DATAW-1:0] pt_q, pt_d;
   logic [4*DATAW-1:0] key_q, key_d;
   logic [DATAW-1:0]   data_hold_q, data_hold_d;
   logic [DATAW-1:0]   key_hold_q, key_hold_d;
   logic               abort_req;

   logic [DATAW-1:0]   enc_data_c;
   logic [DATAW-1:0]   enc_key_c;

`ifdef SIMECK_CTRL_ABORT_EN
   assign abort_req = bus.abort && (state_q != S_IDLE) && (state_q != S_DONE)
                      && (state_q != S_FLUSH);
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         round_q     <= '0;
         pt_q        <= '0;
         key_q       <= '0;
         data_hold_q <= '0;
         key_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         round_q     <= round_d;
         pt_q        <= pt_d;
         key_q       <= key_d;
         data_hold_q <= data_hold_d;
         key_hold_q  <= key_hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.start) state_d = S_INIT;
         S_INIT:   state_d = S_LOAD_D;
         S_LOAD_D: if (phase_q == CW'(1)) state_d = S_LOAD_K;
         S_LOAD_K: if (phase_q == CW'(3)) state_d = S_SEED;
         S_SEED:   state_d = S_ROUND;
         S_ROUND:  if (phase_q == CW'(ROUNDS - 1)) state_d = S_SAVE;
         S_SAVE:   state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         S_FLUSH:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort_req) state_d = S_FLUSH;
   end

   // The single phase counter only runs inside the multi-cycle phases and restarts on every state change.
   always_comb begin
      phase_d = '0;
      if ((state_d == state_q) &&
          (state_q == S_LOAD_D || state_q == S_LOAD_K || state_q == S_ROUND))
         phase_d = phase_q + CW'(1);

      pt_d  = pt_q;
      key_d = key_q;
      if (state_q == S_IDLE && bus.start) begin
         pt_d  = bus.plaintext;
         key_d = bus.key_in;
      end

      round_d = round_q;
      if (state_d == S_INIT)
         round_d = '0;
      else if (state_q == S_ROUND)
         round_d = phase_q;

      enc_data_c = data_hold_q;
      if (state_q == S_LOAD_D)
         enc_data_c = phase_q[0] ? pt_q[DATAW-1:0] : pt_q[2*DATAW-1:DATAW];

      enc_key_c = key_hold_q;
      if (state_q == S_LOAD_K) begin
         unique case (phase_q[1:0])
            2'd0:    enc_key_c = key_q[4*DATAW-1:3*DATAW];
            2'd1:    enc_key_c = key_q[3*DATAW-1:2*DATAW];
            2'd2:    enc_key_c = key_q[2*DATAW-1:DATAW];
            default: enc_key_c = key_q[DATAW-1:0];
         endcase
      end

      data_hold_d = enc_data_c;
      key_hold_d  = enc_key_c;
   end

   always_comb begin
      bus.ready             = (state_q == S_IDLE);
      bus.busy              = (state_q != S_IDLE);
      bus.done              = (state_q == S_DONE);
      bus.round_cnt         = (state_q == S_ROUND) ? phase_q : round_q;
      bus.enc_data          = enc_data_c;
      bus.enc_key           = enc_key_c;
      bus.enc_reset         = (state_q == S_INIT) || (state_q == S_FLUSH);
      bus.enc_shiftregReset = (state_q == S_INIT) || (state_q == S_FLUSH);
      bus.enc_dctr          = (state_q == S_ROUND);
      bus.enc_kctr          = (state_q == S_ROUND);
      bus.enc_lfsrset       = (state_q == S_SEED);
      bus.enc_save          = (state_q == S_SAVE);
`ifdef SIMECK_CTRL_ABORT_EN
      bus.aborted           = (state_q == S_FLUSH);
`endif
   end

endmodule
